// File: rtl/exc_mem_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_mem_if : E-stage inputs and M-stage outputs of the E->M exception stage
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface exc_mem_if;
  logic        valid_E;
  logic [31:0] pc_E;
  logic [31:0] alu_result_E;
  logic [4:0]  exc_code_E;
  logic        bd_E;
  logic [2:0]  mem_op_E;
  logic        eret_E;
  logic        stall_M;
  logic        req;

  logic        valid_M;
  logic [31:0] pc_M;
  logic [31:0] alu_result_M;
  logic [4:0]  ExcCode;
  logic        bd;
  logic        EXLClr;
  logic [2:0]  mem_op_M;
  logic        flush_busy;

  modport master (
    output valid_E, pc_E, alu_result_E, exc_code_E, bd_E, mem_op_E, eret_E,
           stall_M, req,
    input  valid_M, pc_M, alu_result_M, ExcCode, bd, EXLClr, mem_op_M,
           flush_busy
  );

  modport slave (
    input  valid_E, pc_E, alu_result_E, exc_code_E, bd_E, mem_op_E, eret_E,
           stall_M, req,
    output valid_M, pc_M, alu_result_M, ExcCode, bd, EXLClr, mem_op_M,
           flush_busy
  );
endinterface
`default_nettype wire

// File: rtl/exc_mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// exc_mem_stage : E->M pipeline register for the exception path, with AdEL/AdES
//                 alignment check and fixed flush window after a CP0 request.
//                 Optional macro EXC_MEM_CNT_EN adds the exc_count output.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module exc_mem_stage #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'hBFC00000
) (
  input  wire logic   clk,
  input  wire logic   resetn,
  exc_mem_if.slave    bus
`ifdef EXC_MEM_CNT_EN
  ,
  output logic [31:0] exc_count
`endif
);

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_FLUSH     = 1'b1;
  localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [0:0] r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_bubble, w_capture;
  logic       w_load_bubble, w_load_e;
  logic       w_misaligned, w_is_load;
  logic [4:0] w_code;

  logic        r_valid, r_bd, r_eret;
  logic [31:0] r_pc, r_alu;
  logic [4:0]  r_exc;
  logic [2:0]  r_mem_op;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.req) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = C_FLUSH_LOAD;
        end
      end
      default: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
    endcase
  end

  // FLUSH ignores both req and stall_M; only RUN looks at them
  always_comb begin
    w_bubble  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.req)           w_bubble  = 1'b1;
        else if (!bus.stall_M) w_capture = 1'b1;
      end
      default: w_bubble = 1'b1;
    endcase
  end

  assign w_load_bubble = w_bubble | (w_capture & ~bus.valid_E);
  assign w_load_e      = w_capture & bus.valid_E;

  always_comb begin
    w_misaligned = 1'b0;
    w_is_load    = (bus.mem_op_E == 3'd1) || (bus.mem_op_E == 3'd2) ||
                   (bus.mem_op_E == 3'd3);
    case (bus.mem_op_E)
      3'd1, 3'd4: w_misaligned = (bus.alu_result_E[1:0] != 2'b00);
      3'd2, 3'd5: w_misaligned = bus.alu_result_E[0];
      default:    w_misaligned = 1'b0;
    endcase
    // an exception raised earlier in the pipe outranks the address fault
    if (bus.exc_code_E != 5'd0) w_code = bus.exc_code_E;
    else if (w_misaligned)      w_code = w_is_load ? 5'd4 : 5'd5;
    else                        w_code = 5'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn || w_load_bubble) begin
      r_valid  <= 1'b0;
      r_pc     <= RESET_PC;
      r_alu    <= 32'd0;
      r_exc    <= 5'd0;
      r_bd     <= 1'b0;
      r_eret   <= 1'b0;
      r_mem_op <= 3'd0;
    end else if (w_load_e) begin
      r_valid  <= 1'b1;
      r_pc     <= bus.pc_E;
      r_alu    <= bus.alu_result_E;
      r_exc    <= w_code;
      r_bd     <= bus.bd_E;
      r_eret   <= bus.eret_E;
      r_mem_op <= (w_code != 5'd0) ? 3'd0 : bus.mem_op_E;
    end
  end

  assign bus.valid_M      = r_valid;
  assign bus.pc_M         = r_pc;
  assign bus.alu_result_M = r_alu;
  assign bus.ExcCode      = r_valid ? r_exc : 5'd0;
  assign bus.bd           = r_valid & r_bd;
  assign bus.EXLClr       = r_valid & r_eret & (r_exc == 5'd0);
  assign bus.mem_op_M     = r_mem_op;
  assign bus.flush_busy   = (r_state == ST_FLUSH);

`ifdef EXC_MEM_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn)                        exc_count <= 32'd0;
    else if (bus.req && r_state == ST_RUN) exc_count <= exc_count + 32'd1;
  end
`else
`endif

endmodule
`default_nettype wire

// File: doc/exc_mem_stage.md
Name: exc_mem_stage

Overview:
- E->M pipeline register for the exception path; it sits directly upstream of the CP0 block.
- Captures the executed instruction's PC, ALU result, pending exception code, branch-delay flag and ERET marker.
- Adds a load/store address-alignment check (AdEL/AdES) and presents M-stage values to CP0 as pc_M, alu_result_M, ExcCode, bd and EXLClr.
- On a CP0 request it kills the M slot and enforces a fixed flush window while the front end redirects.

Parameters:
- FLUSH_CYCLES, 2, cycles M is held as a bubble after req is seen (1..15).
- RESET_PC, 32'hBFC00000, pc_M value after reset and in bubbles.

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  synchronous reset, active-low; sampled on posedge clk
- valid_E  in  1  E slot holds a real instruction
- pc_E  in  32  E-stage PC
- alu_result_E  in  32  ALU result / effective address
- exc_code_E  in  5  exception accumulated by F/D/E; 0 = none
- bd_E  in  1  E instruction is in a delay slot
- mem_op_E  in  3  0 none, 1 LW, 2 LH/LHU, 3 LB/LBU, 4 SW, 5 SH, 6 SB
- eret_E  in  1  E instruction is ERET
- stall_M  in  1  hold the M register
- req  in  1  CP0 interrupt/exception request
- valid_M  out  1  M slot live
- pc_M  out  32  to CP0
- alu_result_M  out  32  to CP0 (badvaddr source)
- ExcCode  out  5  to CP0; 0 when no exception
- bd  out  1  to CP0
- EXLClr  out  1  to CP0; ERET committing
- mem_op_M  out  3  memory op; forced 0 when ExcCode != 0
- flush_busy  out  1  high while in FLUSH state

Behaviour:
- Reset (resetn=0 at posedge):
  - valid_M=0, pc_M=RESET_PC, alu_result_M=0, ExcCode=0, bd=0, mem_op_M=0.
  - State = RUN, flush counter = 0.
  - Reset has priority over every other input, including mid-FLUSH.
- Alignment check (combinational on E inputs):
  - LW/SW misaligned when addr[1:0] != 0.
  - LH/SH misaligned when addr[0] != 0.
  - Byte ops never misaligned.
  - Misaligned load -> 5'd4 (AdEL); misaligned store -> 5'd5 (AdES).
- Priority: a nonzero exc_code_E always wins over the alignment result; the alignment code is used only when exc_code_E == 0.
- mem_op_M is registered as 0 whenever the resulting code is nonzero.
- FSM, state RUN:
  - req=1 -> load a bubble (valid_M=0, all codes 0, pc_M=RESET_PC). Next state FLUSH, counter = FLUSH_CYCLES-1.
  - else stall_M=1 -> hold all M registers.
  - else -> capture E. If valid_E=0, load a bubble.
- FSM, state FLUSH:
  - Load a bubble every cycle; E inputs are ignored; stall_M is ignored.
  - Decrement the counter; at 0 return to RUN.
  - A req during FLUSH is ignored (CP0 EXL is set).
- Priority on the same edge: resetn=0 > req > stall_M > capture.
- Output gating (combinational):
  - EXLClr = valid_M & eret_M & (ExcCode == 0).
  - ExcCode, bd and EXLClr are all 0 whenever valid_M = 0.
- flush_busy = (state == FLUSH).
- Latency: E inputs appear on M outputs 1 cycle after the capturing edge.
- FLUSH_CYCLES=1: FLUSH lasts exactly one cycle.

Optional Feature:
- Macro: EXC_MEM_CNT_EN.
- When defined:
  - Adds output exc_count[31:0]. It increments by 1 on each posedge where req=1 and state=RUN.
  - Reset value 0; wraps from 32'hFFFFFFFF to 0.
  - When stall_M and req coincide, the count still increments.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with valid_E=1 -> valid_M=0, pc_M=32'hBFC00000, ExcCode=0, flush_busy=0.
- Alignment: LW with alu_result_E=32'h80000002, then SH with 32'h80000001 -> ExcCode=4 then 5; mem_op_M=0 both times; alu_result_M holds the faulting address.
- Priority: exc_code_E=12 (Ov) with misaligned SW -> ExcCode=12, not 5.
- Flush: req=1 on cycle N with FLUSH_CYCLES=2 -> bubbles at N+1, N+2, N+3; flush_busy high N+1..N+2; the E instruction presented at N+3 is captured.
- Stall vs req: stall_M=1 and req=1 on the same edge -> bubble loaded, state FLUSH; stall_M alone for 3 cycles -> M outputs unchanged.
- ERET: eret_E=1, valid_E=1, no exception -> EXLClr=1 for one cycle. With exc_code_E=10 -> EXLClr=0, ExcCode=10. With EXC_MEM_CNT_EN, three separated req pulses -> exc_count=3.
